// File: rtl/task_answer_packer_if.sv
// task_answer_packer_if: sample-in / answer-word-out bundle for the answer packer
interface task_answer_packer_if #(
  parameter int IN_WIDTH  = 8,
  parameter int OUT_WIDTH = 32,
  parameter int CNT_WIDTH = 32,
  parameter int LAT_WIDTH = 32
);
  logic                   i_clear;
  logic                   i_in_valid;
  logic [IN_WIDTH-1:0]    i_data;
  logic                   i_valid;
  logic                   i_last;
  logic                   o_ready;
  logic [OUT_WIDTH-1:0]   o_data;
  logic [OUT_WIDTH/8-1:0] o_strb;
  logic                   o_valid;
  logic                   o_last;
  logic                   i_ready;
  logic [CNT_WIDTH-1:0]   o_size_bytes;
  logic [LAT_WIDTH-1:0]   o_latency;
  logic                   o_overflow;
  modport master (
    output i_clear, i_in_valid, i_data, i_valid, i_last, i_ready,
    input  o_ready, o_data, o_strb, o_valid, o_last, o_size_bytes, o_latency, o_overflow
  );
  modport slave (
    input  i_clear, i_in_valid, i_data, i_valid, i_last, i_ready,
    output o_ready, o_data, o_strb, o_valid, o_last, o_size_bytes, o_latency, o_overflow
  );
endinterface

// File: rtl/task_answer_packer.sv
// task_answer_packer: packs serial samples into wide answer words behind a FWFT FIFO,
// and measures answer size in bytes and task latency in cycles.
module task_answer_packer #(
  parameter int IN_WIDTH   = 8,
  parameter int OUT_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32,
  parameter int LAT_WIDTH  = 32
) (
  input logic i_clk,
  input logic i_rst_n,
  task_answer_packer_if.slave bus
);
  localparam int K  = OUT_WIDTH / IN_WIDTH;
  localparam int PW = K > 1 ? $clog2(K) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int SB = OUT_WIDTH / 8;
  localparam int IB = IN_WIDTH / 8;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [LAT_WIDTH-1:0] LAT_MAX = '1;
  localparam logic [1:0] IDLE = 2'd0, COUNT = 2'd1, DONE = 2'd2;

  if (IN_WIDTH < 8 || IN_WIDTH % 8 != 0) begin : g_bad_in
    $error("IN_WIDTH must be a positive multiple of 8");
  end
  if (OUT_WIDTH < IN_WIDTH || OUT_WIDTH % IN_WIDTH != 0) begin : g_bad_out
    $error("OUT_WIDTH must be a multiple of IN_WIDTH");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2, at least 2");
  end
  if (CNT_WIDTH < 1 || LAT_WIDTH < 1) begin : g_bad_cnt
    $error("CNT_WIDTH and LAT_WIDTH must be positive");
  end

  logic [PW-1:0]        p;
  logic [OUT_WIDTH-1:0] acc, word;
  logic [SB-1:0]        acc_strb, word_strb;
  logic [OUT_WIDTH-1:0] mem_data [FIFO_DEPTH];
  logic [SB-1:0]        mem_strb [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] mem_last;
  logic [AW:0]          wp, rp;
  logic                 full, empty, accept, complete, pop;
  logic [CNT_WIDTH-1:0] running, running_inc, size_bytes;
  logic [LAT_WIDTH-1:0] cnt, latency;
  logic [1:0]           state;
  logic                 overflow;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty       = wp == rp;
  assign full        = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign accept      = bus.i_valid && !full && !bus.i_clear;
  assign complete    = accept && (bus.i_last || p == PW'(K - 1));
  assign pop         = !empty && bus.i_ready && !bus.i_clear;
  assign word        = acc | (OUT_WIDTH'(bus.i_data) << (p * IN_WIDTH));
  assign word_strb   = acc_strb | (SB'({IB{1'b1}}) << (p * IB));
  assign running_inc = running > CNT_MAX - CNT_WIDTH'(IB) ? CNT_MAX : running + CNT_WIDTH'(IB);

  assign bus.o_ready      = !full;
  assign bus.o_valid      = !empty;
  assign bus.o_data       = empty ? '0 : mem_data[rp[AW-1:0]];
  assign bus.o_strb       = empty ? '0 : mem_strb[rp[AW-1:0]];
  assign bus.o_last       = !empty && mem_last[rp[AW-1:0]];
  assign bus.o_size_bytes = size_bytes;
  assign bus.o_latency    = latency;
  assign bus.o_overflow   = overflow;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p        <= '0;
      acc      <= '0;
      acc_strb <= '0;
      wp       <= '0;
      rp       <= '0;
    end else if (bus.i_clear) begin
      p        <= '0;
      acc      <= '0;
      acc_strb <= '0;
      wp       <= '0;
      rp       <= '0;
    end else begin
      if (accept) begin
        p        <= complete ? '0 : p + 1'b1;
        acc      <= complete ? '0 : word;
        acc_strb <= complete ? '0 : word_strb;
      end
      if (complete) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (complete) begin
      mem_data[wp[AW-1:0]] <= word;
      mem_strb[wp[AW-1:0]] <= word_strb;
      mem_last[wp[AW-1:0]] <= bus.i_last;
    end
  end

  // IDLE is only reachable through reset or clear, so latency is already 0 there.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      running    <= '0;
      size_bytes <= '0;
      overflow   <= 1'b0;
      cnt        <= '0;
      latency    <= '0;
      state      <= IDLE;
    end else if (bus.i_clear) begin
      running    <= '0;
      size_bytes <= '0;
      overflow   <= 1'b0;
      cnt        <= '0;
      latency    <= '0;
      state      <= IDLE;
    end else begin
      if (bus.i_valid && full) overflow <= 1'b1;
      if (accept) begin
        running <= bus.i_last ? '0 : running_inc;
        if (bus.i_last) size_bytes <= running_inc;
      end
      if (state == IDLE && bus.i_in_valid) begin
        state <= accept ? DONE : COUNT;
        cnt   <= LAT_WIDTH'(1);
      end else if (state == COUNT) begin
        if (accept) begin
          state   <= DONE;
          latency <= cnt;
        end else begin
          cnt <= cnt == LAT_MAX ? cnt : cnt + 1'b1;
        end
      end
    end
  end
endmodule
